execute_pipe_64: RTL
====================

EXECUTE_PIPE_64 -- requirements
Module: execute_pipe_64

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; legal values 8..64, multiples of 8.
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiply (OPq ifun 4); when 0, ifun 4 is treated as an invalid function.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an instruction is presented on icode/ifun/valA/valB/valC/dstE.
REQ-006 in_ready  output  1  block accepts an instruction this cycle; accept = in_valid & in_ready.
REQ-007 icode, ifun  input  4 each  Y86 instruction code and function.
REQ-008 valA, valB, valC  input  WIDTH each  operands.
REQ-009 dstE  input  4  destination register id.
REQ-010 cc_en  input  1  permits condition-code update for the accepted instruction.
REQ-011 flush  input  1  discards any in-flight instruction.
REQ-012 out_valid  output  1  one-cycle pulse per completed instruction.
REQ-013 valE  output  WIDTH  registered ALU result.
REQ-014 out_valA  output  WIDTH  registered copy of valA.
REQ-015 cndn  output  1  registered condition result.
REQ-016 out_dstE  output  4  registered dstE, or 4'hF when suppressed.
REQ-017 cndnflag  output  3  condition-code register {ZF,SF,OF} (bit2 ZF, bit1 SF, bit0 OF).
REQ-018 busy  output  1  multiply in progress.

Function
REQ-019 State machine IDLE/MUL; in_ready = 1 in IDLE, 0 in MUL.
REQ-020 Non-multiply instructions: accept at edge k; outputs registered at edge k; out_valid high for exactly the cycle after edge k.
REQ-021 valE: icode 2 -> valA; 3 -> valC; 4,5 -> valB+valC; 8,A -> valB-WIDTH/8; 9,B -> valB+WIDTH/8; 6 -> valB op valA; 7 -> 0; any other icode -> 0 with cndn=0.
REQ-022 OPq ifun: 0 add, 1 sub (valB-valA), 2 and, 3 xor, 4 mul; ifun 5..F -> valE 0, no CC update; all arithmetic modulo 2^WIDTH.
REQ-023 OF: add = operands same sign and result sign differs; sub = valB, valA signs differ and result sign differs from valB; and/xor = 0; mul = 1 if the upper WIDTH bits of the unsigned 2*WIDTH product are nonzero.
REQ-024 ZF = result==0; SF = result MSB.
REQ-025 CC updates only on completion of a valid OPq with cc_en=1 captured at accept; never on other icodes.
REQ-026 cndn for icode 2 and 7 from ifun on the CC value before this instruction: 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne ~ZF, 5 ge ~(SF^OF), 6 g ~(SF^OF)&~ZF, 7..F -> 0; cndn=1 for 3,4,5,6,8,9,A,B.
REQ-027 icode 2 with cndn=0 drives out_dstE=4'hF; otherwise out_dstE=dstE.
REQ-028 Multiply: accept at edge k enters MUL, unsigned shift-add, one multiplier bit per cycle; result, CC and out_valid registered at edge k+WIDTH; returns to IDLE at that edge.
REQ-029 Back-to-back: instruction accepted at edge k+1 sees CC written at edge k.
REQ-030 flush=1 at an edge: state -> IDLE, pending multiply discarded, no out_valid, CC unchanged; flush has priority over a simultaneous accept, which is dropped.
REQ-031 Outputs other than out_valid hold their last values between results.

Reset
REQ-032 rst asserted: state IDLE, in_ready=1, busy=0, out_valid=0, valE=0, out_valA=0, cndn=0, out_dstE=4'hF, cndnflag=3'b100, immediately and independent of clk.
REQ-033 rst during MUL aborts the multiply with no out_valid pulse.

Verification
REQ-034 After reset, OPq add valA=5 valB=3 -> next cycle valE=8, out_valid=1, cndnflag=000.
REQ-035 OPq sub valA=8 valB=8, then jXX ifun 3 -> valE=0, cndnflag=100; jXX cndn=1.
REQ-036 OPq add valA=1 valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0x8000_0000_0000_0000, cndnflag=011.
REQ-037 OPq mul valA=6 valB=7 -> busy=1 and in_ready=0 for 64 cycles, single out_valid, valE=42, cndnflag=000.
REQ-038 With cndnflag=000: cmovl (icode 2 ifun 2) dstE=3 -> cndn=0, out_dstE=F; pushq valB=0x100 -> valE=0xF8, CC unchanged.
REQ-039 Multiply accepted, flush 10 cycles later -> no out_valid, in_ready=1 next cycle, cndnflag unchanged; rst mid-multiply -> REQ-032 values.

Source files
------------

// File: rtl/execute_pipe_64.sv
// execute_pipe_64 -- Y86 execute stage with registered outputs and an
// optional iterative (shift-add) multiplier for OPq ifun 4.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       instruction handshake (see below)
//   icode, ifun               instruction code / function
//   valA, valB, valC          operands (WIDTH bits)
//   dstE                      destination register id
//   cc_en                     allow condition-code update for this instruction
//   flush                     discard any in-flight instruction
//   out_valid                 one-cycle pulse per completed instruction
//   valE, out_valA            registered ALU result / registered valA
//   cndn, out_dstE            registered condition result / destination
//   cndnflag                  condition codes {ZF,SF,OF}
//   busy                      multiply in progress
//   state_dbg                 current FSM state (0 IDLE, 1 MUL)
//
// Handshake: an instruction is taken on a rising edge where in_valid and
// in_ready are both high and flush is low. in_ready depends only on the FSM
// state (high in IDLE), never on in_valid. A taken non-multiply completes at
// that same edge; a taken multiply completes WIDTH edges later.
module execute_pipe_64 #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE,
  input  logic             cc_en,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] valE,
  output logic [WIDTH-1:0] out_valA,
  output logic             cndn,
  output logic [3:0]       out_dstE,
  output logic [2:0]       cndnflag,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
  state_t state, state_nx;

  logic             accept, is_mul, mul_last;
  logic [WIDTH-1:0] alu_val;
  logic             alu_of, alu_cc, alu_cndn;

  // multiplier datapath
  logic [2*WIDTH-1:0] acc, acc_nx, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      mul_cnt;
  logic [3:0]         m_dste;
  logic [WIDTH-1:0]   m_vala;
  logic               m_cc_en;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == MUL);
  assign state_dbg = state;
  assign accept    = in_valid & in_ready;
  assign is_mul    = (icode == 4'h6) && (ifun == 4'h4) && MUL_EN;
  assign mul_last  = (state == MUL) && (mul_cnt == CW'(WIDTH - 1));
  assign acc_nx    = acc + (mplier[0] ? mcand : '0);

  // Jump / conditional-move predicate evaluated on the current flags.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (fn)
      4'h1:    cond_eval = (sf ^ of) | zf;
      4'h2:    cond_eval = sf ^ of;
      4'h3:    cond_eval = zf;
      4'h4:    cond_eval = ~zf;
      4'h5:    cond_eval = ~(sf ^ of);
      4'h6:    cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept && is_mul) state_nx = MUL;
        MUL:  if (mul_last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Single-cycle ALU for everything except the multiply.
  always_comb begin
    alu_val  = '0;
    alu_of   = 1'b0;
    alu_cc   = 1'b0;
    alu_cndn = 1'b0;
    case (icode)
      4'h2: begin
        alu_val  = valA;
        alu_cndn = cond_eval(ifun, cndnflag);
      end
      4'h3: begin
        alu_val  = valC;
        alu_cndn = 1'b1;
      end
      4'h4, 4'h5: begin
        alu_val  = valB + valC;
        alu_cndn = 1'b1;
      end
      4'h8, 4'hA: begin
        alu_val  = valB - STEP;
        alu_cndn = 1'b1;
      end
      4'h9, 4'hB: begin
        alu_val  = valB + STEP;
        alu_cndn = 1'b1;
      end
      4'h6: begin
        alu_cndn = 1'b1;
        case (ifun)
          4'h0: begin
            alu_val = valB + valA;
            alu_of  = (valA[WIDTH-1] == valB[WIDTH-1]) && (alu_val[WIDTH-1] != valA[WIDTH-1]);
            alu_cc  = 1'b1;
          end
          4'h1: begin
            alu_val = valB - valA;
            alu_of  = (valA[WIDTH-1] != valB[WIDTH-1]) && (alu_val[WIDTH-1] != valB[WIDTH-1]);
            alu_cc  = 1'b1;
          end
          4'h2: begin
            alu_val = valB & valA;
            alu_cc  = 1'b1;
          end
          4'h3: begin
            alu_val = valB ^ valA;
            alu_cc  = 1'b1;
          end
          default: ;  // invalid function (incl. ifun 4 without multiplier)
        endcase
      end
      4'h7: alu_cndn = cond_eval(ifun, cndnflag);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      valE      <= '0;
      out_valA  <= '0;
      cndn      <= 1'b0;
      out_dstE  <= 4'hF;
      cndnflag  <= 3'b100;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_cnt   <= '0;
      m_dste    <= 4'hF;
      m_vala    <= '0;
      m_cc_en   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (!flush) begin
        if (state == IDLE && accept) begin
          if (is_mul) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, valB};
            mplier  <= valA;
            mul_cnt <= '0;
            m_dste  <= dstE;
            m_vala  <= valA;
            m_cc_en <= cc_en;
          end else begin
            valE      <= alu_val;
            out_valA  <= valA;
            cndn      <= alu_cndn;
            out_dstE  <= (icode == 4'h2 && !alu_cndn) ? 4'hF : dstE;
            out_valid <= 1'b1;
            if (alu_cc && cc_en)
              cndnflag <= {alu_val == '0, alu_val[WIDTH-1], alu_of};
          end
        end else if (state == MUL) begin
          acc     <= acc_nx;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_last) begin
            // acc_nx already includes the final multiplier bit
            valE      <= acc_nx[WIDTH-1:0];
            out_valA  <= m_vala;
            cndn      <= 1'b1;
            out_dstE  <= m_dste;
            out_valid <= 1'b1;
            if (m_cc_en)
              cndnflag <= {acc_nx[WIDTH-1:0] == '0, acc_nx[WIDTH-1],
                           |acc_nx[2*WIDTH-1:WIDTH]};
          end
        end
      end
    end
  end

endmodule
